wb_timeout_bridge: RTL and testbench
====================================

// Module: wb_timeout_bridge
// PURPOSE
//  Registered single-outstanding Wishbone bridge between the network adapter's master port and the tile
//  peripheral slave (SPI top). Forwards one classic-cycle request at a time and returns the slave's
//  response. If the slave gives no ack/err within TIMEOUT cycles, the bridge aborts and returns an error,
//  so the NA never hangs. Keeps a sticky timeout flag and a saturating timeout counter for debug.
// PARAMETERS
//  AW       32    address width
//  DW       32    data width
//  TIMEOUT  1024  max cycles m_cyc_o/m_stb_o held without response; legal range >= 2
// PORTS
//  clk            in   1      tile clock; all logic on rising edge
//  rst            in   1      synchronous, active-high reset
//  s_adr_i        in   AW     upstream (NA master) address
//  s_dat_i        in   DW     upstream write data
//  s_sel_i        in   DW/8   upstream byte select
//  s_we_i         in   1      upstream write enable
//  s_cyc_i        in   1      upstream cycle
//  s_stb_i        in   1      upstream strobe
//  s_dat_o        out  DW     read data returned upstream
//  s_ack_o        out  1      upstream ack, one-cycle pulse
//  s_err_o        out  1      upstream err, one-cycle pulse (slave err or timeout)
//  m_adr_o        out  AW     downstream (peripheral) address, registered
//  m_dat_o        out  DW     downstream write data, registered
//  m_sel_o        out  DW/8   downstream byte select, registered
//  m_we_o         out  1      downstream write enable, registered
//  m_cyc_o        out  1      downstream cycle
//  m_stb_o        out  1      downstream strobe (equal to m_cyc_o)
//  m_dat_i        in   DW     downstream read data
//  m_ack_i        in   1      downstream ack
//  m_err_i        in   1      downstream err
//  clr_i          in   1      one-cycle pulse: clears timeout_flag_o and timeout_cnt_o
//  timeout_flag_o out  1      sticky: at least one timeout since reset/clear
//  timeout_cnt_o  out  8      saturating count of timeouts (max 255)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including s_dat_o and the m_* address/data/sel regs; wait counter 0.
//  States: IDLE, REQ, RESP.
//  IDLE: if s_cyc_i&s_stb_i, capture adr/dat/sel/we into the m_* regs.
//    Next cycle: m_cyc_o=m_stb_o=1, wait counter=0, go to REQ.
//    m_ack_i/m_err_i are ignored in IDLE and RESP.
//  REQ: m_* signals are held stable. Wait counter increments each cycle. Priority, highest first:
//    1) s_cyc_i==0 (upstream abort): drop m_cyc/stb next cycle, go to IDLE, no upstream response.
//    2) m_err_i: drop m_cyc/stb, s_err_o=1 next cycle, go to RESP.
//    3) m_ack_i: s_dat_o<=m_dat_i (reads and writes), drop m_cyc/stb, s_ack_o=1 next cycle, go to RESP.
//    4) wait counter == TIMEOUT-1: drop m_cyc/stb, s_err_o=1 next cycle, go to RESP.
//       Set timeout_flag_o. Increment timeout_cnt_o, saturating at 255.
//  Ack or err arriving in the same cycle as the timeout terminal count wins; it is not counted as a timeout.
//  Ack and err in the same cycle: err wins.
//  RESP: s_ack_o or s_err_o is high for exactly this one cycle; go to IDLE.
//    A request still asserted in the following IDLE cycle is treated as a new request.
//  Latency: request sampled at T -> m_stb_o at T+1; slave ack at T+k -> s_ack_o at T+k+1.
//    Zero-wait slave (ack at T+1) -> s_ack_o at T+2.
//  Throughput: at most one transaction per 3 cycles.
//  s_dat_o holds its value until the next ack.
//  clr_i has priority over a same-cycle timeout increment: the result is 0.
//  Reset mid-transaction: m_cyc_o drops in the reset cycle's next state; no response is ever issued.
// TESTING
//  1. Read, slave acks 2 cycles after m_stb_o with m_dat_i=32'hDEADBEEF
//     -> s_ack_o pulses once at T+4; s_dat_o=32'hDEADBEEF; s_err_o stays 0.
//  2. Write adr=0x40, dat=0x5A, sel=4'h1; hold s_adr_i/s_dat_i changing after T
//     -> m_* regs show captured values for the whole cycle; one s_ack_o pulse.
//  3. TIMEOUT=8, slave never responds -> m_cyc_o high for exactly 8 cycles; s_err_o one pulse;
//     timeout_flag_o=1; timeout_cnt_o=1.
//  4. Slave acks on the terminal-count cycle -> s_ack_o (not s_err_o); timeout_cnt_o unchanged.
//     Same-cycle m_ack_i & m_err_i -> s_err_o only.
//  5. Upstream drops s_cyc_i after 2 cycles in REQ -> m_cyc_o low next cycle; no ack/err upstream;
//     a late m_ack_i is ignored.
//  6. 300 back-to-back timeouts -> timeout_cnt_o saturates at 255; clr_i pulse -> flag=0, cnt=0;
//     rst mid-REQ -> all outputs 0.

Source files
------------

// File: rtl/wb_timeout_bridge.sv
// wb_timeout_bridge: single-outstanding Wishbone bridge that answers with an error when the slave goes silent
module wb_timeout_bridge #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   s_adr_i,
   input  logic [DW-1:0]   s_dat_i,
   input  logic [DW/8-1:0] s_sel_i,
   input  logic            s_we_i,
   input  logic            s_cyc_i,
   input  logic            s_stb_i,
   output logic [DW-1:0]   s_dat_o,
   output logic            s_ack_o,
   output logic            s_err_o,
   output logic [AW-1:0]   m_adr_o,
   output logic [DW-1:0]   m_dat_o,
   output logic [DW/8-1:0] m_sel_o,
   output logic            m_we_o,
   output logic            m_cyc_o,
   output logic            m_stb_o,
   input  logic [DW-1:0]   m_dat_i,
   input  logic            m_ack_i,
   input  logic            m_err_i,
   input  logic            clr_i,
   output logic            timeout_flag_o,
   output logic [7:0]      timeout_cnt_o
);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t state, state_next;
   logic [CW-1:0] wait_cnt;
   logic start, abort, err_hit, ack_hit, timeout_hit;
   assign m_cyc_o = state == REQ;
   assign m_stb_o = m_cyc_o;
   // next state plus the REQ priority chain: abort, err, ack, then timeout
   always_comb begin
      state_next  = state;
      start       = 1'b0;
      abort       = 1'b0;
      err_hit     = 1'b0;
      ack_hit     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            start      = s_cyc_i & s_stb_i;
            state_next = start ? REQ : IDLE;
         end
         REQ: begin
            abort       = ~s_cyc_i;
            err_hit     = s_cyc_i & m_err_i;
            ack_hit     = s_cyc_i & ~m_err_i & m_ack_i;
            timeout_hit = s_cyc_i & ~m_err_i & ~m_ack_i & (wait_cnt == CW'(TIMEOUT - 1));
            state_next  = abort ? IDLE : (err_hit | ack_hit | timeout_hit) ? RESP : REQ;
         end
         default: state_next = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_next;
   end
   // request capture, wait counter and the one-cycle upstream response
   always_ff @(posedge clk) begin
      if (rst) begin
         m_adr_o  <= '0;
         m_dat_o  <= '0;
         m_sel_o  <= '0;
         m_we_o   <= 1'b0;
         wait_cnt <= '0;
         s_dat_o  <= '0;
         s_ack_o  <= 1'b0;
         s_err_o  <= 1'b0;
      end else begin
         if (start) begin
            m_adr_o <= s_adr_i;
            m_dat_o <= s_dat_i;
            m_sel_o <= s_sel_i;
            m_we_o  <= s_we_i;
         end
         wait_cnt <= (state == REQ) ? wait_cnt + 1'b1 : '0;
         if (ack_hit) s_dat_o <= m_dat_i;
         s_ack_o <= ack_hit;
         s_err_o <= err_hit | timeout_hit;
      end
   end
   // sticky timeout flag and saturating timeout count; a clear beats a same-cycle timeout
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         timeout_flag_o <= 1'b0;
         timeout_cnt_o  <= '0;
      end else if (timeout_hit) begin
         timeout_flag_o <= 1'b1;
         timeout_cnt_o  <= timeout_cnt_o + {7'd0, timeout_cnt_o != 8'hFF};
      end
   end
endmodule

// File: tb/tb_wb_timeout_bridge.sv
// tb_wb_timeout_bridge: scoreboard bench for the Wishbone timeout bridge
module tb_wb_timeout_bridge;
   localparam int TO = 8;
   typedef struct {logic err; logic [31:0] dat;} rsp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] s_adr_i = '0, s_dat_i = '0, s_dat_o, m_adr_o, m_dat_o, m_dat_i = '0;
   logic [3:0] s_sel_i = '0, m_sel_o;
   logic s_we_i = 1'b0, s_cyc_i = 1'b0, s_stb_i = 1'b0, s_ack_o, s_err_o;
   logic m_we_o, m_cyc_o, m_stb_o, m_ack_i = 1'b0, m_err_i = 1'b0, clr_i = 1'b0, timeout_flag_o;
   logic [7:0] timeout_cnt_o;
   int n_chk = 0, n_fail = 0, exp_cnt = 0;
   logic exp_flag = 1'b0;
   logic [31:0] last_rdat = '0;
   rsp_t q[$];
   rsp_t mon_e;
   wb_timeout_bridge #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_sel_i(s_sel_i),
      .s_we_i(s_we_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_dat_o(s_dat_o),
      .s_ack_o(s_ack_o), .s_err_o(s_err_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
      .m_sel_o(m_sel_o), .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
      .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .clr_i(clr_i),
      .timeout_flag_o(timeout_flag_o), .timeout_cnt_o(timeout_cnt_o)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // every upstream response must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && (s_ack_o || s_err_o)) begin
         check("ack_err_excl", s_ack_o & s_err_o, 0);
         if (q.size() == 0) check("unexpected_rsp", 1, 0);
         else begin
            mon_e = q.pop_front();
            check("rsp_err", s_err_o, mon_e.err);
            check("rsp_ack", s_ack_o, !mon_e.err);
            check("rsp_dat", s_dat_o, mon_e.dat);
         end
      end
   end
   // mode: 0 ack, 1 err, 2 ack+err together, 3 silent slave; clr_at pulses clr_i in that REQ cycle
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input int delay, input int mode, input logic [31:0] rdat, input int clr_at);
      int n = 0, cyc_n = 0, lat;
      lat = (mode == 3) ? TO : delay + 1;
      q.push_back(rsp_t'{mode != 0, (mode == 0) ? rdat : last_rdat});
      if (mode == 0) last_rdat = rdat;
      s_we_i = we; s_adr_i = adr; s_dat_i = dat; s_sel_i = sel; s_cyc_i = 1'b1; s_stb_i = 1'b1;
      tick();
      s_adr_i = ~adr; s_dat_i = ~dat; s_sel_i = ~sel; s_we_i = ~we;
      while (!(s_ack_o || s_err_o) && n < 40) begin
         if (m_cyc_o) begin
            cyc_n++;
            check("m_stb", m_stb_o, 1);
            check("m_adr", m_adr_o, adr);
            check("m_dat", m_dat_o, dat);
            check("m_sel", m_sel_o, sel);
            check("m_we", m_we_o, we);
         end
         m_ack_i = (n == delay) && (mode == 0 || mode == 2);
         m_err_i = (n == delay) && (mode == 1 || mode == 2);
         m_dat_i = (n == delay) ? rdat : $urandom;
         clr_i = n == clr_at;
         tick();
         n++;
      end
      m_ack_i = 1'b0; m_err_i = 1'b0; clr_i = 1'b0; s_cyc_i = 1'b0; s_stb_i = 1'b0;
      check("resp_seen", s_ack_o | s_err_o, 1);
      check("latency", n, lat);
      check("cyc_len", cyc_n, lat);
      check("m_cyc_resp", m_cyc_o, 0);
      tick();
      check("single_pulse", s_ack_o | s_err_o, 0);
      if (clr_at >= 0) begin exp_flag = 1'b0; exp_cnt = 0; end
      if (mode == 3 && clr_at != TO - 1) begin
         exp_flag = 1'b1;
         exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      end
      check("to_flag", timeout_flag_o, exp_flag);
      check("to_cnt", timeout_cnt_o, exp_cnt);
   endtask
   initial begin
      tick(); tick();
      rst = 1'b0;
      check("rst_cyc", m_cyc_o, 0);
      check("rst_ack", s_ack_o | s_err_o, 0);
      check("rst_sdat", s_dat_o, 0);
      check("rst_madr", m_adr_o, 0);
      check("rst_cnt", {timeout_flag_o, timeout_cnt_o}, 0);
      xfer(1'b0, 32'h10, 32'h0, 4'hF, 2, 0, 32'hDEADBEEF, -1);
      xfer(1'b1, 32'h40, 32'h5A, 4'h1, 1, 0, 32'h1234_5678, -1);
      xfer(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 32'hCAFE_0001, -1);
      xfer(1'b0, 32'h48, 32'h0, 4'hF, -1, 3, 32'h0, -1);
      xfer(1'b0, 32'h4C, 32'h0, 4'hF, TO - 1, 0, 32'hA5A5_0F0F, -1);
      xfer(1'b0, 32'h50, 32'h0, 4'hF, 3, 2, 32'h7777_7777, -1);
      xfer(1'b1, 32'h54, 32'h9, 4'h3, TO - 1, 1, 32'h6666_6666, -1);
      s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = 32'h80;
      tick(); tick();
      check("abort_pre", m_cyc_o, 1);
      s_cyc_i = 1'b0; s_stb_i = 1'b0;
      tick();
      check("abort_drop", m_cyc_o, 0);
      m_ack_i = 1'b1; m_dat_i = 32'hBAD0_BAD0;
      tick();
      m_ack_i = 1'b0;
      check("late_ack", s_ack_o | s_err_o, 0);
      check("late_dat", s_dat_o, last_rdat);
      tick();
      check("late_idle", m_cyc_o | s_ack_o | s_err_o, 0);
      for (int i = 0; i < 300; i++) xfer(1'b0, 32'h100 + i, 32'h0, 4'hF, -1, 3, 32'h0, -1);
      check("sat_cnt", timeout_cnt_o, 255);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("clr_flag", timeout_flag_o, 0);
      check("clr_cnt", timeout_cnt_o, 0);
      exp_flag = 1'b0; exp_cnt = 0;
      xfer(1'b0, 32'h200, 32'h0, 4'hF, -1, 3, 32'h0, -1);
      xfer(1'b0, 32'h204, 32'h0, 4'hF, -1, 3, 32'h0, TO - 1);
      xfer(1'b0, 32'h208, 32'h0, 4'hF, -1, 3, 32'h0, 2);
      xfer(1'b0, 32'h20C, 32'h0, 4'hF, 1, 0, 32'h0BAD_F00D, -1);
      s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_adr_i = 32'h300; s_dat_i = 32'h55; s_sel_i = 4'hF;
      tick(); tick();
      check("mid_req", m_cyc_o, 1);
      rst = 1'b1; s_cyc_i = 1'b0; s_stb_i = 1'b0;
      tick();
      rst = 1'b0;
      check("mrst_cyc", {m_cyc_o, m_stb_o, m_we_o}, 0);
      check("mrst_madr", m_adr_o, 0);
      check("mrst_mdat", m_dat_o, 0);
      check("mrst_msel", m_sel_o, 0);
      check("mrst_sdat", s_dat_o, 0);
      check("mrst_rsp", s_ack_o | s_err_o, 0);
      check("mrst_to", {timeout_flag_o, timeout_cnt_o}, 0);
      exp_flag = 1'b0; exp_cnt = 0; last_rdat = '0;
      tick();
      check("post_rst_rsp", s_ack_o | s_err_o, 0);
      xfer(1'b0, 32'h400, 32'h0, 4'hF, 2, 0, 32'hFACE_B00C, -1);
      tick(); tick();
      check("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
